// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard controller. Detects load-use hazards, flushes
//             IF/ID on taken branches and (optionally) stalls the front end
//             for a fixed number of cycles while a mult/div is in flight.
//             Also counts front-end stall cycles (saturating).
//  Options  : `define HAZARD_MULDIV_EN to build the mult/div stall FSM
//             (MD_BUSY state and md_cnt). Without it id_muldiv_start is
//             ignored and md_busy is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4      // mult/div stall cycles, 1..63
) (
    input  logic        clk,
    input  logic        reset,                 // asynchronous, active-low
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    input  logic        branch_taken,
    input  logic        id_muldiv_start,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);

    // Asserted levels of the IF/ID control strobes.
    localparam logic IF_ID_WRITE_ON = 1'b1;
    localparam logic IF_ID_FLUSH_ON = 1'b1;

    localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

    logic w_load_use;
    logic w_md_busy;

    // A load into $zero never produces a usable value, so it cannot hazard.
    assign w_load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                        ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));

`ifdef HAZARD_MULDIV_EN
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [5:0] c_MD_LOAD = 6'(MD_LATENCY - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_md_cnt;
    logic [5:0] w_md_cnt_next;

    // State register and mult/div countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= RUN;
            r_md_cnt <= 6'd0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    // Next state: a mult/div issues in RUN unless held by a load-use stall;
    // MD_BUSY is left once the counter has run down to zero.
    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        case (r_state)
            RUN: begin
                if (!w_load_use && id_muldiv_start) begin
                    w_state_next  = MD_BUSY;
                    w_md_cnt_next = c_MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (r_md_cnt == 6'd0) begin
                    w_state_next = RUN;
                end else begin
                    w_md_cnt_next = r_md_cnt - 6'd1;
                end
            end
            default: begin
                w_state_next  = RUN;
                w_md_cnt_next = 6'd0;
            end
        endcase
    end

    assign w_md_busy = (r_state == MD_BUSY);
`else
    // Without the mult/div option the start strobe and latency are unused.
    logic w_unused_muldiv;
    assign w_unused_muldiv = id_muldiv_start ^ (MD_LATENCY == 0);
    assign w_md_busy       = 1'b0;
`endif

    assign md_busy = w_md_busy;

    // Front-end control, priority: reset > mult/div stall > load-use > branch.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = IF_ID_WRITE_ON;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!reset) begin
            // hold the pass-through defaults while in reset
        end else if (w_md_busy || w_load_use) begin
            pc_write    = 1'b0;
            if_id_write = ~IF_ID_WRITE_ON;
            id_ex_flush = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = IF_ID_FLUSH_ON;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (!pc_write && (stall_cnt != c_STALL_MAX)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire
